// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: signed speed to dead-time protected complementary PWM.
// Build option SPD_SLEW_EN limits duty change per PWM period to SLEW_STEP.

module mtr_pwm_nov #(
  parameter int DEAD_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pwm1,
  output logic pwm2
);

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } nov_st_e;

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

  nov_st_e    state_q, state_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       raw_q, raw_d;
  logic       pwm1_q, pwm1_d;
  logic       pwm2_q, pwm2_d;
  logic       raw_edge;

  assign raw_edge = raw ^ raw_q;
  assign raw_d    = raw;

  // State register. raw_q resets high because the reset duty
  // (50%) makes raw high at cnt 0, so release sees no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEAD;
      dcnt_q  <= 8'd0;
      raw_q   <= 1'b1;
      pwm1_q  <= 1'b0;
      pwm2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      raw_q   <= raw_d;
      pwm1_q  <= pwm1_d;
      pwm2_q  <= pwm2_d;
    end
  end

  // Next state: any raw edge restarts the dead interval.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      DRIVE: begin
        if (raw_edge) begin
          state_d = DEAD;
          dcnt_d  = 8'd0;
        end
      end
      DEAD: begin
        if (raw_edge) begin
          dcnt_d = 8'd0;
        end else if (dcnt_q == DEAD_LAST) begin
          state_d = DRIVE;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = DEAD;
        dcnt_d  = 8'd0;
      end
    endcase
  end

  // Outputs: legs only follow raw while driving, else both off.
  always_comb begin
    pwm1_d = 1'b0;
    pwm2_d = 1'b0;
    if (state_d == DRIVE) begin
      pwm1_d = raw;
      pwm2_d = ~raw;
    end
  end

  assign pwm1 = pwm1_q;
  assign pwm2 = pwm2_q;

endmodule

module mtr_pwm_drv #(
  parameter int DEAD_CYC  = 32,
  parameter int SLEW_STEP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        pwm_sync
);

  if (DEAD_CYC < 2 || DEAD_CYC > 255 ||
      SLEW_STEP < 1 || SLEW_STEP > 1023) begin : g_bad_param
    $error("mtr_pwm_drv: parameter out of range");
  end

  localparam logic [10:0] DUTY_RST = 11'h400;
  localparam logic [10:0] CNT_LAST = 11'h7FF;

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] lft_duty_q, lft_duty_d;
  logic [10:0] rght_duty_q, rght_duty_d;
  logic        sync_q, sync_d;
  logic [10:0] lft_tgt, rght_tgt;
  logic        lft_raw, rght_raw;
  logic        load;

  // Offset-binary mapping: adding 0x400 mod 2^11 flips the sign bit.
  assign lft_tgt  = {~lft_spd[10], lft_spd[9:0]};
  assign rght_tgt = {~rght_spd[10], rght_spd[9:0]};

  assign load = (cnt_q == CNT_LAST);

`ifdef SPD_SLEW_EN
  localparam logic signed [11:0] STEP_S = 12'(SLEW_STEP);
  localparam logic [10:0]        STEP_U = 11'(SLEW_STEP);

  function automatic logic [10:0] slew(
    input logic [10:0] tgt,
    input logic [10:0] cur
  );
    logic signed [11:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > STEP_S) begin
      return cur + STEP_U;
    end else if (d < -STEP_S) begin
      return cur - STEP_U;
    end else begin
      return tgt;
    end
  endfunction
`endif

  // Period counter, sync pulse and shadow duty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 11'd0;
      lft_duty_q  <= DUTY_RST;
      rght_duty_q <= DUTY_RST;
      sync_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lft_duty_q  <= lft_duty_d;
      rght_duty_q <= rght_duty_d;
      sync_q      <= sync_d;
    end
  end

  // Duties change only on the last count so a period is never split.
  always_comb begin
    cnt_d       = cnt_q + 11'd1;
    sync_d      = load;
    lft_duty_d  = lft_duty_q;
    rght_duty_d = rght_duty_q;
    if (load) begin
`ifdef SPD_SLEW_EN
      lft_duty_d  = slew(lft_tgt, lft_duty_q);
      rght_duty_d = slew(rght_tgt, rght_duty_q);
`else
      lft_duty_d  = lft_tgt;
      rght_duty_d = rght_tgt;
`endif
    end
  end

  // Raw comparator outputs, pre dead-time.
  assign lft_raw  = (cnt_q < lft_duty_q);
  assign rght_raw = (cnt_q < rght_duty_q);

  mtr_pwm_nov #(
    .DEAD_CYC(DEAD_CYC)
  ) u_lft_nov (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (lft_raw),
    .pwm1 (lftPWM1),
    .pwm2 (lftPWM2)
  );

  mtr_pwm_nov #(
    .DEAD_CYC(DEAD_CYC)
  ) u_rght_nov (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rght_raw),
    .pwm1 (rghtPWM1),
    .pwm2 (rghtPWM2)
  );

  assign pwm_sync = sync_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// tb_mtr_pwm_drv: directed checks of mtr_pwm_drv waveforms.
// Expected legs derived by hand from duty and 32-clock dead time.

module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] lft_spd = 11'd0;
  logic [10:0] rght_spd = 11'd0;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] m_cnt = 11'd0;

  always #5 clk = ~clk;

  mtr_pwm_drv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_spd (lft_spd),
    .rght_spd(rght_spd),
    .lftPWM1 (lftPWM1),
    .lftPWM2 (lftPWM2),
    .rghtPWM1(rghtPWM1),
    .rghtPWM2(rghtPWM2),
    .pwm_sync(pwm_sync)
  );

  task automatic step;
    @(posedge clk);
    #1;
    m_cnt = m_cnt + 11'd1;
  endtask

  task automatic run_to(input logic [10:0] c);
    while (m_cnt != c) step();
  endtask

  // Release reset at a negedge and check three periods at zero speed.
  task automatic run_zero_periods(input string tag);
    int el1, el2, er1, er2, es, ov;
    logic e1, e2, esy;
    el1 = 0; el2 = 0; er1 = 0; er2 = 0; es = 0; ov = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 11'd0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 2048; k++) begin
        e1  = (m_cnt >= 11'd33 && m_cnt <= 11'h400) ||
              (p == 0 && m_cnt == 11'd32);
        e2  = (m_cnt >= 11'h421) || (p > 0 && m_cnt == 11'd0);
        esy = (p > 0 && m_cnt == 11'd0);
        if (lftPWM1 !== e1) el1++;
        if (lftPWM2 !== e2) el2++;
        if (rghtPWM1 !== e1) er1++;
        if (rghtPWM2 !== e2) er2++;
        if (pwm_sync !== esy) es++;
        if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) ov++;
        step();
      end
    end
    vectors++;
    if (el1 !== 0) begin
      miscompares++;
      $display("FAIL %s_lft1: %0d bad cycles, required 0", tag, el1);
    end
    vectors++;
    if (el2 !== 0) begin
      miscompares++;
      $display("FAIL %s_lft2: %0d bad cycles, required 0", tag, el2);
    end
    vectors++;
    if (er1 !== 0) begin
      miscompares++;
      $display("FAIL %s_rght1: %0d bad cycles, required 0", tag, er1);
    end
    vectors++;
    if (er2 !== 0) begin
      miscompares++;
      $display("FAIL %s_rght2: %0d bad cycles, required 0", tag, er2);
    end
    vectors++;
    if (es !== 0) begin
      miscompares++;
      $display("FAIL %s_sync: %0d bad cycles, required 0", tag, es);
    end
    vectors++;
    if (ov !== 0) begin
      miscompares++;
      $display("FAIL %s_overlap: %0d cycles, required 0", tag, ov);
    end
  endtask

  task automatic test_reset;
    lft_spd  = 11'd0;
    rght_spd = 11'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b required 00000",
               {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync});
    end
    run_zero_periods("reset");
  endtask

  // Full scale: check the second period after the new duty lands.
  task automatic test_full_scale(input logic [10:0] spd,
                                 input bit fwd, input string tag);
    int e1, e2, ov;
    e1 = 0; e2 = 0; ov = 0;
    lft_spd = spd;
    run_to(11'h7FF);
    step();
    repeat (2048) step();
    for (int k = 0; k < 2048; k++) begin
      if (fwd) begin
        if (lftPWM1 !== (m_cnt >= 11'd33)) e1++;
        if (lftPWM2 !== 1'b0) e2++;
      end else begin
        if (lftPWM1 !== 1'b0) e1++;
        if (lftPWM2 !== 1'b1) e2++;
      end
      if (lftPWM1 && lftPWM2) ov++;
      step();
    end
    vectors++;
    if (e1 !== 0) begin
      miscompares++;
      $display("FAIL %s_pwm1: %0d bad cycles, required 0", tag, e1);
    end
    vectors++;
    if (e2 !== 0) begin
      miscompares++;
      $display("FAIL %s_pwm2: %0d bad cycles, required 0", tag, e2);
    end
    vectors++;
    if (ov !== 0) begin
      miscompares++;
      $display("FAIL %s_overlap: %0d cycles, required 0", tag, ov);
    end
  endtask

  task automatic test_shadow;
    int e1, e2;
    logic x1, x2;
    e1 = 0; e2 = 0;
    run_to(11'h200);
    rght_spd = 11'h100;
    for (int k = 0; k < 2048 - 512; k++) begin
      x1 = (m_cnt >= 11'd33 && m_cnt <= 11'h400);
      x2 = (m_cnt >= 11'h421);
      if (rghtPWM1 !== x1) e1++;
      if (rghtPWM2 !== x2) e2++;
      step();
    end
    vectors++;
    if (e1 + e2 !== 0) begin
      miscompares++;
      $display("FAIL shadow_old_period: %0d bad cycles, required 0",
               e1 + e2);
    end
    e1 = 0; e2 = 0;
    for (int k = 0; k < 2048; k++) begin
      x1 = (m_cnt >= 11'd33 && m_cnt <= 11'h500);
      x2 = (m_cnt >= 11'h521) || (m_cnt == 11'd0);
      if (rghtPWM1 !== x1) e1++;
      if (rghtPWM2 !== x2) e2++;
      step();
    end
    vectors++;
    if (e1 !== 0) begin
      miscompares++;
      $display("FAIL shadow_new_pwm1: %0d bad cycles, required 0", e1);
    end
    vectors++;
    if (e2 !== 0) begin
      miscompares++;
      $display("FAIL shadow_new_pwm2: %0d bad cycles, required 0", e2);
    end
  endtask

  task automatic test_mid_reset;
    lft_spd  = 11'd0;
    rght_spd = 11'd0;
    run_to(11'h100);
    vectors++;
    if ({rghtPWM1, lftPWM2} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrst_pre: got %b required 11",
               {rghtPWM1, lftPWM2});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got %b required 00000",
               {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync});
    end
    run_zero_periods("midrst");
  endtask

  task automatic test_duty_update;
    int n, want;
    lft_spd = 11'h200;
    run_to(11'h7FF);
    step();
    for (int p = 0; p < 2; p++) begin
      n = 0;
      for (int k = 0; k < 2048; k++) begin
        if (lftPWM1 === 1'b1) n++;
        step();
      end
`ifdef SPD_SLEW_EN
      want = (p == 0) ? 'h3F0 : 'h400;
`else
      want = 'h5E0;
`endif
      vectors++;
      if (n !== want) begin
        miscompares++;
        $display("FAIL duty_update_p%0d: high %0d clocks, required %0d",
                 p, n, want);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_scale(11'h3FF, 1'b1, "fwd");
    test_full_scale(11'h400, 1'b0, "rev");
    test_shadow();
    test_mid_reset();
    test_duty_update();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
